// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM port arbiter: state encoding, port indices
// and default bus widths.
package mem_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;
    localparam int P0_CNT_W   = 3;
    localparam int TCNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] PORT_VGA  = 2'd0;
    localparam logic [1:0] PORT_CAM  = 2'd1;
    localparam logic [1:0] PORT_UART = 2'd2;

    function automatic logic [2:0] port_onehot(input logic [1:0] port);
        case (port)
            PORT_VGA:  return 3'b001;
            PORT_CAM:  return 3'b010;
            PORT_UART: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Winner selection: port 0 has priority, bounded by a burst counter so ports
// 1/2 cannot starve; ports 1 and 2 alternate via the rr bit.
module rr_pick
    import mem_pkg::*;
#(
    parameter int P0_BURST = 4
) (
    input  logic [2:0]          req,
    input  logic                rr,
    input  logic [P0_CNT_W-1:0] p0_cnt,
    output logic                valid,
    output logic [1:0]          port
);

    localparam logic [P0_CNT_W-1:0] P0_MAX = P0_CNT_W'(P0_BURST);

    logic starve_s;

    // rr = 0 prefers port 1, rr = 1 prefers port 2
    always_comb begin
        valid    = 1'b0;
        port     = PORT_VGA;
        starve_s = (p0_cnt == P0_MAX) && (req[1] || req[2]);
        if (req[0] && !starve_s) begin
            valid = 1'b1;
            port  = PORT_VGA;
        end else if (req[1] && req[2]) begin
            valid = 1'b1;
            port  = rr ? PORT_UART : PORT_CAM;
        end else if (req[1]) begin
            valid = 1'b1;
            port  = PORT_CAM;
        end else if (req[2]) begin
            valid = 1'b1;
            port  = PORT_UART;
        end else begin
            valid = 1'b0;
            port  = PORT_VGA;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter for the single ram_ctrl SRAM port (VGA, camera, UART dump).
// One word per grant; ack/err pulse on entry to RELEASE.
module sram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TIMEOUT  = 255,
    parameter int P0_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          ack,
    output logic [2:0]          err,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [TCNT_W-1:0]   TIMEOUT_C = TCNT_W'(TIMEOUT);
    localparam logic [P0_CNT_W-1:0] P0_MAX    = P0_CNT_W'(P0_BURST);

    arb_state_t          state_r;
    logic [TCNT_W-1:0]   tcnt_r;
    logic [P0_CNT_W-1:0] p0_cnt_r;
    logic                rr_r;
    logic                is_write_r;

    logic                pick_valid_s;
    logic [1:0]          pick_port_s;
    logic                p12_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    rr_pick #(.P0_BURST(P0_BURST)) u_rr_pick (
        .req    (req),
        .rr     (rr_r),
        .p0_cnt (p0_cnt_r),
        .valid  (pick_valid_s),
        .port   (pick_port_s)
    );

    // Route the winning port's transaction fields to the latch inputs
    always_comb begin
        p12_s = req[1] || req[2];
        case (pick_port_s)
            PORT_VGA: begin
                sel_we_s    = we[0];
                sel_addr_s  = addr[0*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[0*DATA_W +: DATA_W];
            end
            PORT_CAM: begin
                sel_we_s    = we[1];
                sel_addr_s  = addr[1*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[1*DATA_W +: DATA_W];
            end
            PORT_UART: begin
                sel_we_s    = we[2];
                sel_addr_s  = addr[2*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[2*DATA_W +: DATA_W];
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = '0;
                sel_wdata_s = '0;
            end
        endcase
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            tcnt_r     <= '0;
            p0_cnt_r   <= '0;
            rr_r       <= 1'b0;
            is_write_r <= 1'b0;
            ack        <= 3'b000;
            err        <= 3'b000;
            rdata      <= '0;
            busy       <= 1'b0;
            grant_id   <= PORT_VGA;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            ack <= 3'b000;
            err <= 3'b000;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_r    <= ST_ACCESS;
                        busy       <= 1'b1;
                        grant_id   <= pick_port_s;
                        tcnt_r     <= '0;
                        is_write_r <= sel_we_s;
                        mem_read   <= !sel_we_s;
                        mem_write  <= sel_we_s;
                        mem_addr   <= sel_addr_s;
                        mem_wdata  <= sel_wdata_s;
                        if (pick_port_s == PORT_VGA) begin
                            // burst count only advances while someone else waits
                            if (p12_s && (p0_cnt_r != P0_MAX)) begin
                                p0_cnt_r <= p0_cnt_r + P0_CNT_W'(1);
                            end
                        end else begin
                            p0_cnt_r <= '0;
                            rr_r     <= (pick_port_s == PORT_CAM);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (mem_done) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!is_write_r) begin
                            rdata <= mem_rdata;
                        end
                        ack     <= port_onehot(grant_id);
                        state_r <= ST_RELEASE;
                    end else if (tcnt_r == TIMEOUT_C) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        ack       <= port_onehot(grant_id);
                        err       <= port_onehot(grant_id);
                        state_r   <= ST_RELEASE;
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // ram_ctrl must drop workdone before the next strobe
                    if (!mem_done) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed transactions with hand-computed
// expectations, a behavioural ram_ctrl model and a decoupled output monitor.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [59:0] addr_v;
    logic [95:0] wdata_v;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rdata;
    logic        busy;
    logic [1:0]  grant_id;
    logic        mem_read;
    logic        mem_write;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    sram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req_v),
        .we        (we_v),
        .addr      (addr_v),
        .wdata     (wdata_v),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .grant_id  (grant_id),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
    } job_t;

    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          width;
    } exp_t;

    job_t jq0[$];
    job_t jq1[$];
    job_t jq2[$];
    exp_t exp_q[$];
    logic [31:0] mem [logic [19:0]];
    logic [2:0] active;
    int lat;
    int hold;
    int total;
    int passed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add_job(input int p, input logic we, input logic [19:0] a, input logic [31:0] wd);
        job_t j;
        j.we = we;
        j.addr = a;
        j.wdata = wd;
        case (p)
            0: jq0.push_back(j);
            1: jq1.push_back(j);
            default: jq2.push_back(j);
        endcase
    endtask

    task automatic expect_txn(input logic [1:0] port, input logic we, input logic [19:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er, input int w);
        exp_t e;
        e.port = port;
        e.we = we;
        e.addr = a;
        e.wdata = wd;
        e.rdata = rd;
        e.err = er;
        e.width = w;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || active != 3'b000 || (jq0.size() + jq1.size() + jq2.size()) != 0)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < 3000), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    // Requesters: hold each job until its ack, then immediately present the next
    initial begin
        int wait_n [3];
        job_t j;
        logic have;
        req_v = 3'b000;
        we_v = 3'b000;
        addr_v = '0;
        wdata_v = '0;
        active = 3'b000;
        for (int p = 0; p < 3; p++) wait_n[p] = 0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (active[p] && ack[p]) begin
                    active[p] = 1'b0;
                    req_v[p] = 1'b0;
                end
                if (!active[p]) begin
                    have = 1'b0;
                    case (p)
                        0: if (jq0.size() > 0) begin j = jq0.pop_front(); have = 1'b1; end
                        1: if (jq1.size() > 0) begin j = jq1.pop_front(); have = 1'b1; end
                        default: if (jq2.size() > 0) begin j = jq2.pop_front(); have = 1'b1; end
                    endcase
                    if (have) begin
                        active[p] = 1'b1;
                        req_v[p] = 1'b1;
                        we_v[p] = j.we;
                        addr_v[p*20 +: 20] = j.addr;
                        wdata_v[p*32 +: 32] = j.wdata;
                        wait_n[p] = 0;
                    end
                end else begin
                    wait_n[p]++;
                    if (wait_n[p] > 2000) begin
                        total++;
                        $display("FAIL req_timeout: port %0d got no ack within 2000 cycles", p);
                        active[p] = 1'b0;
                        req_v[p] = 1'b0;
                    end
                end
            end
        end
    end

    // ram_ctrl model: workdone after lat strobe cycles (lat 0 = never), held hold extra cycles
    initial begin
        int cnt;
        int hcnt;
        mem_done = 1'b0;
        mem_rdata = '0;
        cnt = 0;
        hcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_done = 1'b0;
                cnt = 0;
            end else if (mem_done) begin
                cnt = 0;
                if (hcnt == 0) mem_done = 1'b0;
                else hcnt--;
            end else if (mem_read || mem_write) begin
                cnt++;
                if (lat != 0 && cnt == lat) begin
                    mem_done = 1'b1;
                    hcnt = hold;
                    cnt = 0;
                    if (mem_write) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0000_0000;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: check issue on strobe rise, completion on ack
    initial begin
        int width;
        logic prev_strobe;
        logic strobe;
        exp_t e;
        width = 0;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                width = 0;
                prev_strobe = 1'b0;
            end else begin
                strobe = mem_read || mem_write;
                if (strobe && !prev_strobe) begin
                    width = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL issue_unexpected: strobe for port %0d addr %0h, none expected", grant_id, mem_addr);
                    end else begin
                        e = exp_q[0];
                        chk("issue_port", 64'(grant_id), 64'(e.port));
                        chk("issue_write", 64'(mem_write), 64'(e.we));
                        chk("issue_read", 64'(mem_read), 64'(!e.we));
                        chk("issue_addr", 64'(mem_addr), 64'(e.addr));
                        if (e.we) chk("issue_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                end
                if (strobe) width++;
                if (ack != 3'b000) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL ack_unexpected: ack %b err %b with nothing outstanding", ack, err);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_onehot", 64'(ack), 64'(3'b001 << e.port));
                        chk("ack_err", 64'(err), e.err ? 64'(3'b001 << e.port) : 64'd0);
                        chk("strobe_width", 64'(width), 64'(e.width));
                        if (!e.we && !e.err) chk("ack_rdata", 64'(rdata), 64'(e.rdata));
                    end
                end else if (err != 3'b000) begin
                    total++;
                    $display("FAIL err_without_ack: err %b, expected 000", err);
                end
                prev_strobe = strobe;
            end
        end
    end

    initial begin
        int ord [10];
        int i0;
        int i1;
        int n;
        int gap;
        total = 0;
        passed = 0;
        lat = 4;
        hold = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_read", 64'(mem_read), 64'd0);
        chk("rst_write", 64'(mem_write), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Port-2 read, mem_read high for 4 cycles
        mem[20'h00010] = 32'hDEAD_BEEF;
        expect_txn(2'd2, 1'b0, 20'h00010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
        add_job(2, 1'b0, 20'h00010, 32'h0);
        drain("drain_p2_read");

        // Ports 1 and 2 writing continuously alternate
        lat = 2;
        expect_txn(2'd1, 1'b1, 20'h00100, 32'h1111_0000, 32'h0, 1'b0, 2);
        expect_txn(2'd2, 1'b1, 20'h00200, 32'h2222_0000, 32'h0, 1'b0, 2);
        expect_txn(2'd1, 1'b1, 20'h00101, 32'h1111_0001, 32'h0, 1'b0, 2);
        expect_txn(2'd2, 1'b1, 20'h00201, 32'h2222_0001, 32'h0, 1'b0, 2);
        add_job(1, 1'b1, 20'h00100, 32'h1111_0000);
        add_job(1, 1'b1, 20'h00101, 32'h1111_0001);
        add_job(2, 1'b1, 20'h00200, 32'h2222_0000);
        add_job(2, 1'b1, 20'h00201, 32'h2222_0001);
        drain("drain_rr_writes");

        // Port 0 bursts of 4 while port 1 waits
        lat = 1;
        ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) mem[20'h00400 + 20'(i)] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 2; i++) mem[20'h00480 + 20'(i)] = 32'hB000_0000 + 32'(i);
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (ord[k] == 0) begin
                expect_txn(2'd0, 1'b0, 20'h00400 + 20'(i0), 32'h0, 32'hA000_0000 + 32'(i0), 1'b0, 1);
                i0++;
            end else begin
                expect_txn(2'd1, 1'b0, 20'h00480 + 20'(i1), 32'h0, 32'hB000_0000 + 32'(i1), 1'b0, 1);
                i1++;
            end
        end
        for (int i = 0; i < 8; i++) add_job(0, 1'b0, 20'h00400 + 20'(i), 32'h0);
        for (int i = 0; i < 2; i++) add_job(1, 1'b0, 20'h00480 + 20'(i), 32'h0);
        drain("drain_p0_burst");

        // Timeout: no workdone, err after 256 strobe cycles, then normal service
        lat = 0;
        expect_txn(2'd1, 1'b0, 20'h00333, 32'h0, 32'h0, 1'b1, 256);
        add_job(1, 1'b0, 20'h00333, 32'h0);
        drain("drain_timeout");
        lat = 2;
        mem[20'h00334] = 32'h1234_5678;
        expect_txn(2'd1, 1'b0, 20'h00334, 32'h0, 32'h1234_5678, 1'b0, 2);
        add_job(1, 1'b0, 20'h00334, 32'h0);
        drain("drain_after_timeout");

        // workdone held 5 extra cycles delays the next strobe
        lat = 3;
        hold = 5;
        expect_txn(2'd0, 1'b1, 20'h00700, 32'h55AA_55AA, 32'h0, 1'b0, 3);
        expect_txn(2'd2, 1'b0, 20'h00700, 32'h0, 32'h55AA_55AA, 1'b0, 3);
        add_job(0, 1'b1, 20'h00700, 32'h55AA_55AA);
        add_job(2, 1'b0, 20'h00700, 32'h0);
        n = 0;
        while (ack[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_ack_seen", 64'(n < 200), 64'd1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!mem_read && gap < 50);
        chk("hold_gap", 64'(gap), 64'd7);
        drain("drain_hold");
        hold = 0;

        // Reset mid-ACCESS: strobes drop at once, no ack, re-arbitration from rr = port 1
        lat = 0;
        mem[20'h00500] = 32'h0BAD_F00D;
        mem[20'h00600] = 32'hFEED_FACE;
        expect_txn(2'd1, 1'b0, 20'h00500, 32'h0, 32'h0BAD_F00D, 1'b0, 2);
        add_job(1, 1'b0, 20'h00500, 32'h0);
        n = 0;
        while (!mem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_strobe", 64'(mem_read), 64'd1);
        repeat (5) @(negedge clk);
        expect_txn(2'd2, 1'b0, 20'h00600, 32'h0, 32'hFEED_FACE, 1'b0, 2);
        add_job(2, 1'b0, 20'h00600, 32'h0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_read", 64'(mem_read), 64'd0);
        chk("async_rst_write", 64'(mem_write), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_ack", 64'(ack), 64'd0);
        lat = 2;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
